shift_unit_arbiter: RTL and testbench
=====================================

Name: shift_unit_arbiter

Overview:
Shares one right_shift_unit datapath among NUM_REQ requesters, for example the ALU issue port, the address-generation path and the multi-precision microcode sequencer. Arbitration is round-robin and work-conserving. The block has a one-entry registered result stage with a valid/ready handshake, so the result is returned to the winner tagged with its requester index. It instantiates right_shift_unit internally and sits between the issue logic and the ALU result bus.

Parameters:
WORD_WIDTH, 16, datapath width; must be a power of two, >= 4.
NUM_REQ, 4, number of requesters; 2..8.
ID_W, $clog2(NUM_REQ) (derived, localparam), width of the requester tag.

Ports:
clk_i  in  1  clock; all state updates on the rising edge.
rst_i  in  1  reset; asynchronous, active-high.
req_valid_i  in  NUM_REQ  per-requester request valid.
req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
req_op_i  in  NUM_REQ*2  per-requester shift type, forwarded unchanged to the unit's op_i.
req_a_i  in  NUM_REQ*WORD_WIDTH  per-requester operand a.
req_b_i  in  NUM_REQ*WORD_WIDTH  per-requester shift amount; only the low $clog2(WORD_WIDTH) bits are used.
req_c_i  in  NUM_REQ*(WORD_WIDTH-1)  per-requester fill bits.
req_cf_i  in  NUM_REQ  per-requester carry-in.
rsp_valid_o  out  1  result register holds a valid result.
rsp_ready_i  in  1  consumer accepts the result.
rsp_id_o  out  ID_W  index of the requester that produced the result.
rsp_r_o  out  WORD_WIDTH  shift result.
rsp_cf_o  out  1  carry-out.
busy_o  out  1  equals rsp_valid_o; used by the hazard unit.

Behaviour:
- Slot free: slot_free = ~rsp_valid_o | rsp_ready_i.
- Grant: combinational and round-robin. Starting from pointer ptr, the first index i (modulo NUM_REQ) with req_valid_i[i]=1 wins.
- req_ready_o[i] = (i == winner) & any_valid & slot_free. All other bits are 0.
- Accept: occurs when req_valid_i[w] & req_ready_o[w]. The winner's operands drive the unit.
  - On the edge, rsp_r_o, rsp_cf_o and rsp_id_o load the unit outputs and w.
  - rsp_valid_o becomes 1.
  - ptr becomes (w+1) mod NUM_REQ.
- Latency and throughput: 1 cycle from accept to rsp_valid_o. Back-to-back accepts are allowed when rsp_ready_i=1, giving 1 result per cycle.
- Drain without new accept: if rsp_valid_o & rsp_ready_i and nothing is accepted, rsp_valid_o becomes 0. Data registers hold their value.
- Backpressure: if rsp_valid_o & ~rsp_ready_i, then req_ready_o = 0 and all result registers hold. ptr does not move.
- Simultaneous drain and accept: the new result replaces the old in the same edge; no bubble.
- No valid request: ptr holds. The arbiter never grants an idle requester.
- Fairness: a requester that holds valid is granted within NUM_REQ accepts.
- Handshake rules for requesters:
  - A requester must hold valid and operands stable until its ready is seen.
  - The arbiter may change the winner between cycles only if no accept occurred. With ptr fixed, the winner is stable while the slot is blocked.
- Width rules: shift amount = req_b_i[w][$clog2(WORD_WIDTH)-1:0]. Upper bits of b are ignored.
- Reset (asynchronous, mid-operation included): rsp_valid_o=0, rsp_r_o=0, rsp_cf_o=0, rsp_id_o=0, ptr=0, busy_o=0. A result held at reset is discarded. req_ready_o is 0 while rst_i=1.
- X-safety: operand muxes select by one-hot grant. With no grant, the unit inputs are 0.

Decomposition:
- Package shift_arb_pkg: typedef shift_op_t (2-bit) and the function rr_pick(valid, ptr), which returns the winner index and a found flag.
- Natural sub-module: rr_arbiter (parameter N). It holds the ptr register, the combinational pick and the update-on-accept, and is reusable for the load/store port arbiter.
- The top level contains the operand mux, the right_shift_unit instance and the result register.

Test Plan:
- Single requester, WORD_WIDTH=16, req 2 valid, a=16'h8000, b=16'h0004, logical op, rsp_ready=1 -> ready[2]=1 in the same cycle. Next cycle: rsp_valid=1, rsp_id=2, r=16'h0800. Following cycle (no new accept): rsp_valid=0.
- All 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,1 over 6 consecutive cycles; one result per cycle.
- Backpressure: a result is pending and rsp_ready=0 for 3 cycles while req 1 and req 3 are valid -> req_ready=0 throughout; rsp_* stable; ptr unchanged. After rsp_ready=1, req 1 is accepted in that cycle.
- Simultaneous drain and accept: rsp_valid=1, rsp_ready=1, req 0 valid -> next cycle rsp_id=0 with the new data; rsp_valid stays 1.
- b upper bits: b=16'hFFF3, a=16'h00F0, logical op -> r equals the result for shift 3 (16'h001E); the carry-out matches a unit-level reference model.
- Asynchronous reset asserted mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately, ptr=0. After release, with requests 1 and 3 valid, req 1 wins first.

Source files
------------

// File: rtl/shift_unit_arbiter_pkg.sv
// shift_arb_pkg: shared shift-op type and round-robin pick helper for the shift unit arbiter
// Provides shift_op_t, pick_t and rr_pick(valid, ptr, n) -> {found, idx}.
package shift_arb_pkg;
    typedef enum logic [1:0] {OP_LSR, OP_ASR, OP_ROR, OP_FILL} shift_op_t;
    localparam int MAX_REQ = 8;
    typedef struct packed {
        logic       found;
        logic [2:0] idx;
    } pick_t;
    // First valid index scanning upward from ptr, wrapping modulo n.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid, input logic [2:0] ptr, input int n);
        pick_t p;
        int    j;
        p = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            j = (int'(ptr) + k) % n;
            if (k < n && !p.found && valid[j]) begin
                p.found = 1'b1;
                p.idx   = 3'(j);
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/right_shift_unit.sv
// right_shift_unit: right shift of a by shamt with selectable fill (zero, sign, rotate, external c)
// Ports: op_i shift type, a_i operand, shamt_i amount, c_i fill bits, cf_i carry-in,
//        r_o result, cf_o carry-out (last bit shifted out, or cf_i when shamt is 0).
module right_shift_unit
    import shift_arb_pkg::*;
#(
    parameter int W = 16,
    localparam int SW = $clog2(W)
) (
    input  shift_op_t       op_i,
    input  logic [W-1:0]    a_i,
    input  logic [SW-1:0]   shamt_i,
    input  logic [W-2:0]    c_i,
    input  logic            cf_i,
    output logic [W-1:0]    r_o,
    output logic            cf_o
);
    logic [W-2:0] w_fill;
    assign w_fill = op_i == OP_ASR  ? {(W-1){a_i[W-1]}} :
                    op_i == OP_ROR  ? a_i[W-2:0] :
                    op_i == OP_FILL ? c_i : '0;
    // fill[k] lands at bit W-shamt+k; W-1-shamt equals ~shamt since W is a power of two
    assign r_o  = (a_i >> shamt_i) | ({w_fill, 1'b0} << ~shamt_i);
    assign cf_o = shamt_i == '0 ? cf_i : a_i[shamt_i - 1'b1];
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: work-conserving round-robin arbiter with pointer advancing past each accepted winner
// Ports: clk_i/rst_i, valid_i requests, en_i slot available, grant_o one-hot winner,
//        ready_o grant gated by en_i, idx_o winner index, accept_o a grant was taken.
module rr_arbiter
    import shift_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = $clog2(N)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic [N-1:0]  valid_i,
    input  logic          en_i,
    output logic [N-1:0]  grant_o,
    output logic [N-1:0]  ready_o,
    output logic [IW-1:0] idx_o,
    output logic          accept_o
);
    logic [IW-1:0]      r_ptr;
    logic [MAX_REQ-1:0] w_valid;
    pick_t              w_pick;
    always_comb begin
        w_valid         = '0;
        w_valid[N-1:0]  = valid_i;
    end
    assign w_pick   = rr_pick(w_valid, 3'(r_ptr), N);
    assign idx_o    = IW'(w_pick.idx);
    assign grant_o  = w_pick.found ? N'(1) << idx_o : '0;
    assign ready_o  = grant_o & {N{en_i}};
    assign accept_o = w_pick.found & en_i;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_ptr <= '0;
        else if (accept_o) r_ptr <= idx_o == IW'(N-1) ? '0 : idx_o + 1'b1;
    end
endmodule

// File: rtl/shift_unit_arbiter.sv
// shift_unit_arbiter: round-robin sharing of one right_shift_unit with a registered, tagged result stage
// Ports: clk_i/rst_i, per-requester req_valid_i/req_ready_o/req_op_i/req_a_i/req_b_i/req_c_i/req_cf_i,
//        result rsp_valid_o/rsp_ready_i/rsp_id_o/rsp_r_o/rsp_cf_o, busy_o mirrors rsp_valid_o.
module shift_unit_arbiter
    import shift_arb_pkg::*;
#(
    parameter int WORD_WIDTH = 16,
    parameter int NUM_REQ = 4,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NUM_REQ-1:0]              req_valid_i,
    output logic [NUM_REQ-1:0]              req_ready_o,
    input  logic [NUM_REQ*2-1:0]            req_op_i,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_a_i,
    input  logic [NUM_REQ*WORD_WIDTH-1:0]   req_b_i,
    input  logic [NUM_REQ*(WORD_WIDTH-1)-1:0] req_c_i,
    input  logic [NUM_REQ-1:0]              req_cf_i,
    output logic                            rsp_valid_o,
    input  logic                            rsp_ready_i,
    output logic [ID_W-1:0]                 rsp_id_o,
    output logic [WORD_WIDTH-1:0]           rsp_r_o,
    output logic                            rsp_cf_o,
    output logic                            busy_o
);
    localparam int W  = WORD_WIDTH;
    localparam int SW = $clog2(W);
    logic               r_valid, r_cf;
    logic [ID_W-1:0]    r_id;
    logic [W-1:0]       r_r;
    logic               w_en, w_acc, w_cf, w_cfo;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_idx;
    logic [1:0]         w_op;
    logic [W-1:0]       w_a, w_r;
    logic [SW-1:0]      w_s;
    logic [W-2:0]       w_c;
    // reset also blocks grants so no request is accepted while rst_i is high
    assign w_en = (~r_valid | rsp_ready_i) & ~rst_i;
    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .valid_i  (req_valid_i),
        .en_i     (w_en),
        .grant_o  (w_grant),
        .ready_o  (req_ready_o),
        .idx_o    (w_idx),
        .accept_o (w_acc)
    );
    // one-hot AND-OR mux: all zeros when nobody is granted
    always_comb begin
        w_op = '0;
        w_a  = '0;
        w_s  = '0;
        w_c  = '0;
        w_cf = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_op = w_op | (w_grant[i] ? req_op_i[i*2 +: 2] : '0);
            w_a  = w_a  | (w_grant[i] ? req_a_i[i*W +: W] : '0);
            w_s  = w_s  | (w_grant[i] ? req_b_i[i*W +: SW] : '0);
            w_c  = w_c  | (w_grant[i] ? req_c_i[i*(W-1) +: W-1] : '0);
            w_cf = w_cf | (w_grant[i] & req_cf_i[i]);
        end
    end
    right_shift_unit #(.W(W)) u_rsu (
        .op_i    (shift_op_t'(w_op)),
        .a_i     (w_a),
        .shamt_i (w_s),
        .c_i     (w_c),
        .cf_i    (w_cf),
        .r_o     (w_r),
        .cf_o    (w_cfo)
    );
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_id    <= '0;
            r_r     <= '0;
            r_cf    <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_id    <= w_idx;
            r_r     <= w_r;
            r_cf    <= w_cfo;
        end else if (rsp_ready_i) begin
            r_valid <= 1'b0;
        end
    end
    assign rsp_valid_o = r_valid;
    assign rsp_id_o    = r_id;
    assign rsp_r_o     = r_r;
    assign rsp_cf_o    = r_cf;
    assign busy_o      = r_valid;
endmodule

// File: tb/tb_shift_unit_arbiter.sv
// tb_shift_unit_arbiter: directed and randomized checks of shift_unit_arbiter against a behavioural model
module tb_shift_unit_arbiter;
    localparam int W = 16;
    localparam int N = 4;
    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_ready;
    logic [N*2-1:0]   req_op;
    logic [N*W-1:0]   req_a, req_b;
    logic [N*(W-1)-1:0] req_c;
    logic [N-1:0]     req_cf;
    logic             rsp_valid, rsp_ready, rsp_cf, busy;
    logic [1:0]       rsp_id;
    logic [W-1:0]     rsp_r;
    logic [N-1:0]     tv;
    logic [1:0]       top_[N];
    logic [W-1:0]     ta[N], tb_[N];
    logic [W-2:0]     tc[N];
    logic [N-1:0]     tcf;
    logic             m_valid, m_cf;
    int               m_id, m_ptr;
    logic [W-1:0]     m_r, r0;
    int               vectors = 0, miscompares = 0, acc;

    always #5 clk = ~clk;

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign req_op[g*2 +: 2]        = top_[g];
        assign req_a[g*W +: W]         = ta[g];
        assign req_b[g*W +: W]         = tb_[g];
        assign req_c[g*(W-1) +: W-1]   = tc[g];
        assign req_cf[g]               = tcf[g];
    end

    shift_unit_arbiter #(.WORD_WIDTH(W), .NUM_REQ(N)) dut (
        .clk_i(clk), .rst_i(rst), .req_valid_i(tv), .req_ready_o(req_ready),
        .req_op_i(req_op), .req_a_i(req_a), .req_b_i(req_b), .req_c_i(req_c), .req_cf_i(req_cf),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
        .rsp_r_o(rsp_r), .rsp_cf_o(rsp_cf), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Bit-by-bit definition: result bit j takes source bit j+s of a, or a fill bit beyond the top.
    function automatic logic [W:0] ref_shift(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-2:0] c, input logic cf);
        int s;
        int src;
        logic [W-1:0] r;
        s = int'(b) % W;
        for (int j = 0; j < W; j++) begin
            src = j + s;
            if (src < W) r[j] = a[src];
            else if (op == 1) r[j] = a[W-1];
            else if (op == 2) r[j] = a[src-W];
            else if (op == 3) r[j] = c[src-W];
            else r[j] = 1'b0;
        end
        return {(s == 0) ? cf : a[s-1], r};
    endfunction

    task automatic model_reset();
        m_valid = 1'b0; m_id = 0; m_r = '0; m_cf = 1'b0; m_ptr = 0;
    endtask

    task automatic rand_ops(input int i);
        top_[i] = 2'($urandom);
        ta[i]   = 16'($urandom);
        tb_[i]  = 16'($urandom);
        tc[i]   = 15'($urandom);
        tcf[i]  = 1'($urandom);
    endtask

    // Called at posedge+1: checks combinational ready, then the registered result after the edge.
    task automatic cycle(input logic rdy, output int a_out);
        int w;
        logic [W:0] rv;
        logic [N-1:0] er;
        rsp_ready = rdy;
        #1;
        w = -1;
        if (!m_valid || rdy)
            for (int k = 0; k < N; k++)
                if (w < 0 && tv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        er = (w >= 0) ? N'(1) << w : '0;
        chk("req_ready", 32'(req_ready), 32'(er));
        @(posedge clk);
        #1;
        if (w >= 0) begin
            rv = ref_shift(int'(top_[w]), ta[w], tb_[w], tc[w], tcf[w]);
            m_valid = 1'b1; m_id = w; m_r = rv[W-1:0]; m_cf = rv[W]; m_ptr = (w + 1) % N;
        end else if (rdy) m_valid = 1'b0;
        chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_valid));
        chk("rsp_id", 32'(rsp_id), 32'(m_id));
        chk("rsp_r", 32'(rsp_r), 32'(m_r));
        chk("rsp_cf", 32'(rsp_cf), 32'(m_cf));
        a_out = w;
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b0; tv = '0; tcf = '0;
        for (int i = 0; i < N; i++) begin top_[i] = '0; ta[i] = '0; tb_[i] = '0; tc[i] = '0; end
        model_reset();
        repeat (2) @(posedge clk);
        tv = 4'b0001;
        #1;
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_id", 32'(rsp_id), 0);
        chk("rst_r", 32'(rsp_r), 0);
        chk("rst_cf", 32'(rsp_cf), 0);
        chk("rst_ready", 32'(req_ready), 0);
        tv = '0;
        rst = 1'b0;
        // single requester
        top_[2] = 2'd0; ta[2] = 16'h8000; tb_[2] = 16'h0004; tv = 4'b0100;
        cycle(1'b1, acc);
        chk("t1_acc", acc, 2);
        chk("t1_id", 32'(rsp_id), 2);
        chk("t1_r", 32'(rsp_r), 32'h0800);
        tv = '0;
        cycle(1'b1, acc);
        chk("t1_drain", 32'(rsp_valid), 0);
        // move pointer to 0, then all requesters continuously
        rand_ops(3); tv = 4'b1000;
        cycle(1'b1, acc);
        for (int i = 0; i < N; i++) rand_ops(i);
        tv = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            cycle(1'b1, acc);
            chk("t2_order", acc, k % N);
            rand_ops(acc);
        end
        tv = 4'b0001;
        cycle(1'b1, acc);
        // backpressure with requests 1 and 3
        rand_ops(1); rand_ops(3); tv = 4'b1010;
        r0 = rsp_r;
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, acc);
            chk("t3_noacc", acc, -1);
            chk("t3_hold", 32'(rsp_r), 32'(r0));
        end
        cycle(1'b1, acc);
        chk("t3_acc", acc, 1);
        // simultaneous drain and accept
        rand_ops(0); tv = 4'b0001;
        cycle(1'b1, acc);
        chk("t4_acc", acc, 0);
        chk("t4_valid", 32'(rsp_valid), 1);
        chk("t4_id", 32'(rsp_id), 0);
        // upper shift-amount bits ignored
        top_[2] = 2'd0; ta[2] = 16'h00F0; tb_[2] = 16'hFFF3; tv = 4'b0100;
        cycle(1'b1, acc);
        chk("t5_r", 32'(rsp_r), 32'h001E);
        // asynchronous reset mid-cycle with a result pending
        #3 rst = 1'b1;
        #1;
        chk("t6_valid", 32'(rsp_valid), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_r", 32'(rsp_r), 0);
        chk("t6_id", 32'(rsp_id), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        rand_ops(1); rand_ops(3); tv = 4'b1010;
        cycle(1'b1, acc);
        chk("t6_first", acc, 1);
        // randomized traffic; a valid requester holds its operands until accepted
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < N; i++)
                if (!tv[i] || acc == i) begin
                    tv[i] = $urandom_range(0, 2) != 0;
                    rand_ops(i);
                end
            cycle($urandom_range(0, 3) != 0, acc);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
